mem_array_search_arbiter: RTL and testbench
===========================================

// Module: mem_array_search_arbiter
// PURPOSE
//  Owns a DEPTH x DATA_W register array with per-entry valid bits and shares it between two requesters.
//  Each requester issues WRITE, INVALIDATE or SEARCH commands; a round-robin arbiter grants one command at a time.
//  SEARCH is a sequential membership scan, one entry per cycle ("is key inside the array"), returning hit and index.
//  Sits between client logic and the storage array; it is the only writer/reader of the array.
// PARAMETERS
//  DATA_W  8   entry/key width
//  DEPTH   16  number of entries (power of two, >=2)
//  ADDR_W  4   log2(DEPTH)
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          reset, asynchronous, active-high
//  req_valid  in   2          per-requester command valid (bit i = requester i)
//  req_ready  out  2          per-requester accept, one-hot or zero
//  req_op     in   4          2 bits/requester: 00 WRITE, 01 SEARCH, 10 INVALIDATE, 11 reserved (treated as INVALIDATE)
//  req_addr   in   2*ADDR_W   entry address per requester (WRITE/INVALIDATE)
//  req_data   in   2*DATA_W   write data or search key per requester
//  rsp_valid  out  1          response valid, held until rsp_ready
//  rsp_ready  in   1          response accept
//  rsp_id     out  1          requester that owns the response
//  rsp_hit    out  1          SEARCH: match found; WRITE/INVALIDATE: 1
//  rsp_index  out  ADDR_W     SEARCH: first matching index (0 on miss); WRITE/INVALIDATE: req_addr
//  rsp_count  out  ADDR_W+1   match count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all entry valid bits 0, array data 0, state IDLE, last_grant=1, req_ready=0, rsp_valid=0,
//   rsp_id/rsp_hit/rsp_index/rsp_count=0.
//  FSM: IDLE -> (accept WRITE/INVALIDATE) -> RESP; IDLE -> (accept SEARCH) -> SCAN -> RESP; RESP -> (rsp_ready) -> IDLE.
//  req_ready: combinational, only in IDLE; single valid -> that requester; both valid -> requester != last_grant.
//  last_grant updates on every accept. First contention after reset grants requester 0.
//  Accept = req_valid[i] & req_ready[i]; op/addr/data captured on that edge.
//  WRITE: mem[addr]<=data, valid[addr]<=1 on accept edge; rsp_valid rises the next cycle (latency 1).
//  INVALIDATE: valid[addr]<=0 on accept edge; data untouched; rsp latency 1.
//  SCAN: scan_idx starts 0 the cycle after accept; compares valid[scan_idx] && mem[scan_idx]==key each cycle.
//   Hit at index k: rsp_valid asserted at accept+2+k. Miss: scan_idx reaches DEPTH-1 without hit, rsp at accept+1+DEPTH.
//   Invalid entries never match, even if data equals key.
//  RESP: outputs stable while rsp_valid && !rsp_ready; no new accept until the response is taken.
//  rsp_ready in the same cycle rsp_valid rises -> IDLE next cycle; a new accept is possible that IDLE cycle.
//  scan_idx is ADDR_W wide; no wrap past DEPTH-1 (scan terminates there).
//  Reset mid-SCAN or mid-RESP: operation abandoned, no response emitted, array contents cleared per reset.
//  req_valid deasserted before accept: no effect; no command is latched.
// CONFIGURATION
//  MEM_ARRAY_MATCH_COUNT_EN defined: SEARCH always scans all DEPTH entries (no early exit).
//   rsp latency fixed at accept+1+DEPTH.
//   rsp_count = number of matching valid entries (0..DEPTH); rsp_index = lowest matching index.
//  Not defined: early exit on first hit; rsp_count driven 0.
// TESTING
//  1. Reset, req0 SEARCH key 8'hA5 -> rsp at accept+17: hit=0, index=0, id=0 (empty array).
//  2. req0 WRITE addr 5 data 8'h3C, then SEARCH 8'h3C -> write rsp at +1 (hit=1, index=5);
//     search rsp at +7 (hit=1, index=5); with MATCH_COUNT_EN: +17, count=1.
//  3. Both requesters valid every cycle, all WRITEs -> grants alternate 0,1,0,1 starting with 0; never both ready.
//  4. WRITE addr 2 = 8'h11, INVALIDATE addr 2, SEARCH 8'h11 -> search miss: hit=0, count=0.
//  5. Hold rsp_ready=0 for 5 cycles after rsp_valid -> outputs stable, req_ready=0;
//     release -> IDLE next cycle, pending requester accepted.
//  6. Assert rst at scan index 7 -> req_ready/rsp_valid 0 immediately; no response; a SEARCH after reset misses.

Source files
------------

// File: rtl/mem_array_search_arbiter.sv
// Two-requester round-robin front end for a DEPTH x DATA_W array with per-entry valid bits.
// Optional build macro MEM_ARRAY_MATCH_COUNT_EN: SEARCH scans every entry and reports the match count.
module mem_array_search_arbiter #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [3:0]            req_op,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic                  rsp_hit,
    output logic [ADDR_W-1:0]     rsp_index,
    output logic [ADDR_W:0]       rsp_count
);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_SEARCH = 2'b01;

    state_t state, next_state;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              valid [DEPTH];
    logic              last_grant;
    logic [ADDR_W-1:0] scan_idx;
    logic [DATA_W-1:0] key;

    logic              grant_id;
    logic              accept;
    logic [1:0]        grant_op;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;
    logic              scan_match;
    logic              scan_last;

    assign grant_id   = req_ready[1];
    assign accept     = |(req_valid & req_ready);
    assign grant_op   = grant_id ? req_op[3:2] : req_op[1:0];
    assign grant_addr = grant_id ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    assign grant_data = grant_id ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
    assign scan_match = valid[scan_idx] && (mem[scan_idx] == key);
    assign scan_last  = (scan_idx == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = (grant_op == OP_SEARCH) ? SCAN : RESP;
`ifdef MEM_ARRAY_MATCH_COUNT_EN
            SCAN: if (scan_last) next_state = RESP;
`else
            SCAN: if (scan_match || scan_last) next_state = RESP;
`endif
            RESP: if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Ready is gated by rst so nothing is offered while reset is held.
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = (state == RESP);
        if (state == IDLE && !rst) begin
            if (&req_valid) req_ready = last_grant ? 2'b01 : 2'b10;
            else            req_ready = req_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         last_grant <= 1'b1;
        else if (accept) last_grant <= grant_id;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mem[g]   <= '0;
                valid[g] <= 1'b0;
            end else if (accept && grant_op != OP_SEARCH && grant_addr == ADDR_W'(g)) begin
                if (grant_op == OP_WRITE) begin
                    mem[g]   <= grant_data;
                    valid[g] <= 1'b1;
                end else begin
                    valid[g] <= 1'b0;
                end
            end
        end
    end

    // Response fields double as scan accumulators; they are only visible once RESP is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_idx  <= '0;
            key       <= '0;
            rsp_id    <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_index <= '0;
            rsp_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rsp_id    <= grant_id;
                        rsp_count <= '0;
                        if (grant_op == OP_SEARCH) begin
                            key       <= grant_data;
                            scan_idx  <= '0;
                            rsp_hit   <= 1'b0;
                            rsp_index <= '0;
                        end else begin
                            rsp_hit   <= 1'b1;
                            rsp_index <= grant_addr;
                        end
                    end
                end
                SCAN: begin
                    if (scan_match && !rsp_hit) begin
                        rsp_hit   <= 1'b1;
                        rsp_index <= scan_idx;
                    end
`ifdef MEM_ARRAY_MATCH_COUNT_EN
                    if (scan_match) rsp_count <= rsp_count + (ADDR_W+1)'(1);
`endif
                    if (!scan_last) scan_idx <= scan_idx + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_array_search_arbiter.sv
// Directed bench for mem_array_search_arbiter: a monitor models the array and scoreboards every response.
module tb_mem_array_search_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_ready;
    logic [3:0] req_op = 4'b0;
    logic [7:0] req_addr = 8'b0;
    logic [15:0] req_data = 16'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic       rsp_id;
    logic       rsp_hit;
    logic [3:0] rsp_index;
    logic [4:0] rsp_count;

    typedef struct {
        logic       id;
        logic       hit;
        logic [3:0] index;
        logic [4:0] count;
        int         lat;
        int         acc_edge;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_mem [16];
    logic       m_valid [16];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    bit         rsp_started = 0;

    mem_array_search_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_hit(rsp_hit), .rsp_index(rsp_index), .rsp_count(rsp_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_search(input logic id, input logic [7:0] k);
        exp_t e;
        e.id = id; e.hit = 1'b0; e.index = 4'd0; e.count = 5'd0; e.acc_edge = 0;
        for (int i = 0; i < 16; i++) begin
            if (m_valid[i] && m_mem[i] == k) begin
                if (!e.hit) begin
                    e.hit = 1'b1;
                    e.index = 4'(i);
                end
`ifdef MEM_ARRAY_MATCH_COUNT_EN
                e.count = e.count + 5'd1;
`endif
            end
        end
`ifdef MEM_ARRAY_MATCH_COUNT_EN
        e.lat = 17;
`else
        e.lat = e.hit ? int'(e.index) + 2 : 17;
`endif
        return e;
    endfunction

    // Monitor: scores responses against the queue head and models each accepted command.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_rsp", {31'b0, rsp_valid}, 32'd0);
                end else begin
                    if (!rsp_started) begin
                        check("rsp_latency", cyc - sb[0].acc_edge + 1, sb[0].lat);
                        rsp_started = 1;
                    end
                    check("rsp_id", rsp_id, sb[0].id);
                    check("rsp_hit", rsp_hit, sb[0].hit);
                    check("rsp_index", rsp_index, sb[0].index);
                    check("rsp_count", rsp_count, sb[0].count);
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        rsp_started = 0;
                    end
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_t e;
                    logic [1:0] op;
                    logic [3:0] a;
                    logic [7:0] d;
                    op = req_op[2*i +: 2];
                    a  = req_addr[4*i +: 4];
                    d  = req_data[8*i +: 8];
                    if (op == 2'b01) begin
                        e = model_search(i[0], d);
                    end else begin
                        if (op == 2'b00) begin
                            m_mem[a] = d;
                            m_valid[a] = 1'b1;
                        end else begin
                            m_valid[a] = 1'b0;
                        end
                        e.id = i[0]; e.hit = 1'b1; e.index = a; e.count = 5'd0; e.lat = 1;
                    end
                    e.acc_edge = cyc + 1;
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        sb.delete();
        rsp_started = 0;
        for (int i = 0; i < 16; i++) begin
            m_mem[i] = 8'h00;
            m_valid[i] = 1'b0;
        end
        #1;
        check("reset_req_ready", req_ready, 2'b00);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        @(negedge clk);
        check("reset_rsp_id", rsp_id, 1'b0);
        check("reset_rsp_hit", rsp_hit, 1'b0);
        check("reset_rsp_index", rsp_index, 4'd0);
        check("reset_rsp_count", rsp_count, 5'd0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        rst = 1'b0;
    endtask

    task automatic apply_stimulus(input int id, input logic [1:0] op, input logic [3:0] addr,
                                  input logic [7:0] data);
        bit got;
        got = 0;
        @(posedge clk); #1;
        req_op[2*id +: 2]   = op;
        req_addr[4*id +: 4] = addr;
        req_data[8*id +: 8] = data;
        req_valid[id] = 1'b1;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1;
        end
        check("accept_timeout", {31'b0, got}, 32'd1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 60 && sb.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        int  grants;
        logic g;
        do_reset();
        check("idle_ready_no_valid", req_ready, 2'b00);

        apply_stimulus(0, 2'b01, 4'd0, 8'hA5);
        wait_drain();

        apply_stimulus(0, 2'b00, 4'd5, 8'h3C);
        wait_drain();
        apply_stimulus(0, 2'b01, 4'd0, 8'h3C);
        wait_drain();
        apply_stimulus(0, 2'b00, 4'd9, 8'h3C);
        wait_drain();
        apply_stimulus(1, 2'b01, 4'd0, 8'h3C);
        wait_drain();

        apply_stimulus(0, 2'b00, 4'd15, 8'hF0);
        wait_drain();
        apply_stimulus(1, 2'b01, 4'd0, 8'hF0);
        wait_drain();
        apply_stimulus(0, 2'b01, 4'd0, 8'h00);
        wait_drain();

        apply_stimulus(0, 2'b00, 4'd2, 8'h11);
        wait_drain();
        apply_stimulus(0, 2'b10, 4'd2, 8'h00);
        wait_drain();
        apply_stimulus(0, 2'b01, 4'd0, 8'h11);
        wait_drain();
        apply_stimulus(1, 2'b00, 4'd3, 8'h22);
        wait_drain();
        apply_stimulus(1, 2'b11, 4'd3, 8'h00);
        wait_drain();
        apply_stimulus(1, 2'b01, 4'd0, 8'h22);
        wait_drain();

        // Response back-pressure with requester 1 waiting
        rsp_ready = 1'b0;
        apply_stimulus(0, 2'b00, 4'd7, 8'h5A);
        req_op[3:2] = 2'b00; req_addr[7:4] = 4'd8; req_data[15:8] = 8'h81;
        req_valid[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid, 1'b1);
            check("hold_req_ready", req_ready, 2'b00);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("release_still_resp", req_ready, 2'b00);
        @(negedge clk);
        check("release_pending_grant", req_ready, 2'b10);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_drain();

        // Contention right after reset: strict alternation starting with requester 0
        do_reset();
        @(posedge clk); #1;
        req_op = 4'b0000;
        req_addr = {4'd8, 4'd0};
        req_data = {8'h80, 8'h40};
        req_valid = 2'b11;
        grants = 0;
        g = 1'b0;
        for (int c = 0; c < 40 && grants < 8; c++) begin
            @(negedge clk);
            check("ready_onehot0", {31'b0, $onehot0(req_ready)}, 32'd1);
            if (req_ready != 2'b00) begin
                check("grant_order", req_ready, g ? 2'b10 : 2'b01);
                grants++;
                @(posedge clk); #1;
                if (g) begin
                    req_addr[7:4] = req_addr[7:4] + 4'd1;
                    req_data[15:8] = req_data[15:8] + 8'd1;
                end else begin
                    req_addr[3:0] = req_addr[3:0] + 4'd1;
                    req_data[7:0] = req_data[7:0] + 8'd1;
                end
                g = ~g;
            end
        end
        check("grant_total", grants, 8);
        req_valid = 2'b00;
        wait_drain();

        // Reset in the middle of a scan abandons the search and clears the array
        apply_stimulus(0, 2'b00, 4'd10, 8'h77);
        wait_drain();
        apply_stimulus(0, 2'b01, 4'd0, 8'h77);
        repeat (7) @(posedge clk);
        #1;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
        end
        check("no_rsp_after_reset", rsp_valid, 1'b0);
        apply_stimulus(0, 2'b01, 4'd0, 8'h77);
        wait_drain();

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
